// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: passive observer of N_CH ap_ctrl_chain handshakes.
// Each channel runs a small IDLE/RUN/WAIT_CONT tracker and keeps saturating
// counters for transactions, active cycles, stall cycles, loop iterations
// and latency. Any counter can be read back through a one-cycle-latency port.
module ap_ctrl_perf_monitor #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [N_CH-1:0]  ap_start,
    input  logic [N_CH-1:0]  ap_ready,
    input  logic [N_CH-1:0]  ap_done,
    input  logic [N_CH-1:0]  ap_continue,
    input  logic [N_CH-1:0]  iter_end,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_ch,
    input  logic [2:0]       rd_field,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic [N_CH-1:0]  busy,
    output logic [N_CH-1:0]  overflow
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        WAIT_CONT = 2'd2
    } chState_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    chState_e         state_q   [N_CH];
    chState_e         state_d   [N_CH];
    logic [CNT_W-1:0] lat_q     [N_CH];
    logic [CNT_W-1:0] lat_d     [N_CH];
    logic [CNT_W-1:0] txn_q     [N_CH];
    logic [CNT_W-1:0] txn_d     [N_CH];
    logic [CNT_W-1:0] active_q  [N_CH];
    logic [CNT_W-1:0] active_d  [N_CH];
    logic [CNT_W-1:0] stall_q   [N_CH];
    logic [CNT_W-1:0] stall_d   [N_CH];
    logic [CNT_W-1:0] iter_q    [N_CH];
    logic [CNT_W-1:0] iter_d    [N_CH];
    logic [CNT_W-1:0] maxLat_q  [N_CH];
    logic [CNT_W-1:0] maxLat_d  [N_CH];
    logic [CNT_W-1:0] lastLat_q [N_CH];
    logic [CNT_W-1:0] lastLat_d [N_CH];
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;
    logic             rdValid_q;
    logic [CNT_W-1:0] rdData_q;
    logic [CNT_W-1:0] rdData_d;

    // Saturating increment; the top bit of the result flags an increment
    // that was attempted while the counter was already at its ceiling.
    function automatic logic [CNT_W:0] satInc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W:0] r;
        r = {1'b0, v};
        if (inc) begin
            if (v == CNT_MAX) begin
                r = {1'b1, v};
            end else begin
                r = {1'b0, v + CNT_ONE};
            end
        end
        return r;
    endfunction

    // Per-channel handshake tracking, latency measurement and counter next-state.
    always_comb begin
        logic           isRun;
        logic           incTxn;
        logic           incAct;
        logic           incStall;
        logic           recLat;
        logic           satHit;
        logic [CNT_W-1:0] curLat;
        logic [CNT_W:0] tmp;
        isRun    = 1'b0;
        incTxn   = 1'b0;
        incAct   = 1'b0;
        incStall = 1'b0;
        recLat   = 1'b0;
        satHit   = 1'b0;
        curLat   = '0;
        tmp      = '0;
        for (int c = 0; c < N_CH; c++) begin
            state_d[c]   = state_q[c];
            lat_d[c]     = lat_q[c];
            txn_d[c]     = txn_q[c];
            active_d[c]  = active_q[c];
            stall_d[c]   = stall_q[c];
            iter_d[c]    = iter_q[c];
            maxLat_d[c]  = maxLat_q[c];
            lastLat_d[c] = lastLat_q[c];
            ovf_d[c]     = ovf_q[c];

            incTxn   = 1'b0;
            incAct   = 1'b0;
            incStall = 1'b0;
            recLat   = 1'b0;
            satHit   = 1'b0;

            // The cycle in which IDLE sees ap_start behaves exactly like a RUN
            // cycle, so a start and done in the same cycle is a 1-cycle job.
            isRun  = (state_q[c] == RUN) || ((state_q[c] == IDLE) && ap_start[c]);
            curLat = (state_q[c] == IDLE) ? CNT_ONE :
                     ((lat_q[c] == CNT_MAX) ? CNT_MAX : lat_q[c] + CNT_ONE);

            if (isRun) begin
                incAct     = 1'b1;
                state_d[c] = RUN;
                lat_d[c]   = curLat;
                if (ap_done[c]) begin
                    recLat = 1'b1;
                    if (ap_continue[c]) begin
                        incTxn     = 1'b1;
                        state_d[c] = ap_start[c] ? RUN : IDLE;
                        lat_d[c]   = ap_start[c] ? CNT_ONE : '0;
                    end else begin
                        incStall   = 1'b1;
                        state_d[c] = WAIT_CONT;
                    end
                end
            end else if (state_q[c] == WAIT_CONT) begin
                incStall = 1'b1;
                if (ap_continue[c]) begin
                    incTxn     = 1'b1;
                    state_d[c] = ap_start[c] ? RUN : IDLE;
                    lat_d[c]   = ap_start[c] ? CNT_ONE : '0;
                end
            end else if (state_q[c] != IDLE) begin
                state_d[c] = IDLE;
                lat_d[c]   = '0;
            end

            if (clear) begin
                txn_d[c]     = '0;
                active_d[c]  = '0;
                stall_d[c]   = '0;
                iter_d[c]    = '0;
                maxLat_d[c]  = '0;
                lastLat_d[c] = '0;
                ovf_d[c]     = 1'b0;
            end else begin
                if ((state_q[c] == WAIT_CONT) && ap_ready[c]) begin
                    ovf_d[c] = 1'b1;
                end
                if (enable) begin
                    tmp         = satInc(txn_q[c], incTxn);
                    txn_d[c]    = tmp[CNT_W-1:0];
                    satHit      = satHit | tmp[CNT_W];
                    tmp         = satInc(active_q[c], incAct);
                    active_d[c] = tmp[CNT_W-1:0];
                    satHit      = satHit | tmp[CNT_W];
                    tmp         = satInc(stall_q[c], incStall);
                    stall_d[c]  = tmp[CNT_W-1:0];
                    satHit      = satHit | tmp[CNT_W];
                    tmp         = satInc(iter_q[c], iter_end[c]);
                    iter_d[c]   = tmp[CNT_W-1:0];
                    satHit      = satHit | tmp[CNT_W];
                    if (recLat) begin
                        lastLat_d[c] = curLat;
                        if (curLat > maxLat_q[c]) begin
                            maxLat_d[c] = curLat;
                        end
                    end
                    if (satHit) begin
                        ovf_d[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Channel state and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]   <= IDLE;
                lat_q[c]     <= '0;
                txn_q[c]     <= '0;
                active_q[c]  <= '0;
                stall_q[c]   <= '0;
                iter_q[c]    <= '0;
                maxLat_q[c]  <= '0;
                lastLat_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c]   <= state_d[c];
                lat_q[c]     <= lat_d[c];
                txn_q[c]     <= txn_d[c];
                active_q[c]  <= active_d[c];
                stall_q[c]   <= stall_d[c];
                iter_q[c]    <= iter_d[c];
                maxLat_q[c]  <= maxLat_d[c];
                lastLat_q[c] <= lastLat_d[c];
            end
            ovf_q <= ovf_d;
        end
    end

    // Readout mux over current register values; unknown channels and fields read 0.
    always_comb begin
        rdData_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ch == SEL_W'(c)) begin
                case (rd_field)
                    3'd0:    rdData_d = txn_q[c];
                    3'd1:    rdData_d = active_q[c];
                    3'd2:    rdData_d = stall_q[c];
                    3'd3:    rdData_d = iter_q[c];
                    3'd4:    rdData_d = maxLat_q[c];
                    3'd5:    rdData_d = lastLat_q[c];
                    default: rdData_d = '0;
                endcase
            end
        end
    end

    // Read response register; data holds its last value between requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdValid_q <= rd_en;
            if (rd_en) begin
                rdData_q <= rdData_d;
            end
        end
    end

    // A channel is busy whenever a transaction is open or awaiting continue.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            busy[c] = (state_q[c] != IDLE);
        end
    end

    assign overflow = ovf_q;
    assign rd_valid = rdValid_q;
    assign rd_data  = rdData_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the monitor.
module tb_ap_ctrl_perf_monitor;

    localparam int NC   = 3;
    localparam int CW   = 8;
    localparam int MAXV = 255;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          clear;
    logic [NC-1:0] ap_start;
    logic [NC-1:0] ap_ready;
    logic [NC-1:0] ap_done;
    logic [NC-1:0] ap_continue;
    logic [NC-1:0] iter_end;
    logic          rd_en;
    logic [1:0]    rd_ch;
    logic [2:0]    rd_field;
    logic          rd_valid;
    logic [CW-1:0] rd_data;
    logic [NC-1:0] busy;
    logic [NC-1:0] overflow;

    int total = 0;
    int bad   = 0;

    // Model of each channel: counters as plain integers, plus where the
    // current job stands (0 none open, 1 executing, 2 finished but held).
    int mTxn[NC];
    int mAct[NC];
    int mStall[NC];
    int mIter[NC];
    int mMax[NC];
    int mLast[NC];
    bit mOvf[NC];
    int mPhase[NC];
    int mElapsed[NC];
    bit expRdValid;
    int expRdData;

    ap_ctrl_perf_monitor #(.N_CH(NC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .iter_end(iter_end),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_field(rd_field),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic modelReset();
        for (int c = 0; c < NC; c++) begin
            mTxn[c] = 0; mAct[c] = 0; mStall[c] = 0; mIter[c] = 0;
            mMax[c] = 0; mLast[c] = 0; mOvf[c] = 0; mPhase[c] = 0; mElapsed[c] = 0;
        end
        expRdValid = 0;
        expRdData  = 0;
    endtask

    function automatic int modelField(int ch, int f);
        if (ch >= NC) return 0;
        case (f)
            0: return mTxn[ch];
            1: return mAct[ch];
            2: return mStall[ch];
            3: return mIter[ch];
            4: return mMax[ch];
            5: return mLast[ch];
            default: return 0;
        endcase
    endfunction

    function automatic int sat(int v, int c);
        if (v >= MAXV) begin
            mOvf[c] = 1;
            return MAXV;
        end
        return v + 1;
    endfunction

    function automatic logic [NC-1:0] modelBusy();
        logic [NC-1:0] b;
        for (int c = 0; c < NC; c++) b[c] = (mPhase[c] != 0);
        return b;
    endfunction

    function automatic logic [NC-1:0] modelOvf();
        logic [NC-1:0] o;
        for (int c = 0; c < NC; c++) o[c] = mOvf[c];
        return o;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int lat;
        int rec;
        bit addTxn, addAct, addStall, proto, working;
        if (rd_en) begin
            expRdValid = 1;
            expRdData  = modelField(int'(rd_ch), int'(rd_field));
        end else begin
            expRdValid = 0;
        end
        for (int c = 0; c < NC; c++) begin
            addTxn = 0; addAct = 0; addStall = 0; rec = 0;
            proto   = (mPhase[c] == 2) && ap_ready[c];
            working = (mPhase[c] == 1) || (mPhase[c] == 0 && ap_start[c]);
            if (working) begin
                lat = (mPhase[c] == 0) ? 1 : ((mElapsed[c] + 1 > MAXV) ? MAXV : mElapsed[c] + 1);
                addAct = 1;
                mElapsed[c] = lat;
                mPhase[c] = 1;
                if (ap_done[c]) begin
                    rec = lat;
                    if (ap_continue[c]) begin
                        addTxn = 1;
                        mPhase[c] = ap_start[c] ? 1 : 0;
                        mElapsed[c] = ap_start[c] ? 1 : 0;
                    end else begin
                        addStall = 1;
                        mPhase[c] = 2;
                    end
                end
            end else if (mPhase[c] == 2) begin
                addStall = 1;
                if (ap_continue[c]) begin
                    addTxn = 1;
                    mPhase[c] = ap_start[c] ? 1 : 0;
                    mElapsed[c] = ap_start[c] ? 1 : 0;
                end
            end
            if (clear) begin
                mTxn[c] = 0; mAct[c] = 0; mStall[c] = 0; mIter[c] = 0;
                mMax[c] = 0; mLast[c] = 0; mOvf[c] = 0;
            end else begin
                if (proto) mOvf[c] = 1;
                if (enable) begin
                    if (addTxn)      mTxn[c]   = sat(mTxn[c], c);
                    if (addAct)      mAct[c]   = sat(mAct[c], c);
                    if (addStall)    mStall[c] = sat(mStall[c], c);
                    if (iter_end[c]) mIter[c]  = sat(mIter[c], c);
                    if (rec > 0) begin
                        mLast[c] = rec;
                        if (rec > mMax[c]) mMax[c] = rec;
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        checkOutput("busy", 64'(busy), 64'(modelBusy()));
        checkOutput("overflow", 64'(overflow), 64'(modelOvf()));
        checkOutput("rd_valid", 64'(rd_valid), 64'(expRdValid));
        checkOutput("rd_data", 64'(rd_data), 64'(expRdData));
    endtask

    // One clock: step the model, let the edge pass, compare 1ns later.
    task automatic applyStimulus();
        if (reset) modelStep();
        else modelReset();
        @(posedge clock);
        #1;
        checkAll();
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
    endtask

    task automatic readCheck(input int ch, input int f, input string tag, input int exp);
        rd_en = 1'b1;
        rd_ch = 2'(ch);
        rd_field = 3'(f);
        applyStimulus();
        checkOutput({tag, "_valid"}, 64'(rd_valid), 64'd1);
        checkOutput(tag, 64'(rd_data), 64'(exp));
        rd_en = 1'b0;
    endtask

    task automatic idleInputs();
        ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0; iter_end = '0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0;
        idleInputs();
        rd_en = 1'b0; rd_ch = '0; rd_field = '0;
        modelReset();
        #1 reset = 1'b0;
        #1;
        checkAll();
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        #1;
        checkAll();
        checkOutput("reset_busy", 64'(busy), 64'd0);

        $display("[TB] single transaction");
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        repeat (4) applyStimulus();
        ap_done[0] = 1'b1; ap_continue[0] = 1'b1; applyStimulus(); idleInputs();
        checkOutput("single_busy_end", 64'(busy), 64'd0);
        readCheck(0, 0, "single_txn", 1);
        readCheck(0, 1, "single_active", 6);
        readCheck(0, 2, "single_stall", 0);
        readCheck(0, 4, "single_max", 6);
        readCheck(0, 5, "single_last", 6);
        readCheck(0, 6, "single_field6", 0);

        $display("[TB] backpressure");
        pulseClear();
        ap_start[1] = 1'b1; applyStimulus(); ap_start[1] = 1'b0;
        checkOutput("bp_busy", 64'(busy[1]), 64'd1);
        applyStimulus();
        checkOutput("bp_busy", 64'(busy[1]), 64'd1);
        ap_done[1] = 1'b1;
        repeat (3) begin
            applyStimulus();
            checkOutput("bp_busy", 64'(busy[1]), 64'd1);
        end
        ap_continue[1] = 1'b1; applyStimulus(); idleInputs();
        checkOutput("bp_busy_end", 64'(busy[1]), 64'd0);
        readCheck(1, 2, "bp_stall", 4);
        readCheck(1, 0, "bp_txn", 1);
        readCheck(1, 5, "bp_last", 3);

        $display("[TB] back-to-back");
        pulseClear();
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        checkOutput("b2b_busy", 64'(busy[0]), 64'd1);
        repeat (2) begin
            applyStimulus();
            checkOutput("b2b_busy", 64'(busy[0]), 64'd1);
        end
        ap_start[0] = 1'b1; ap_done[0] = 1'b1; ap_continue[0] = 1'b1;
        applyStimulus(); idleInputs();
        checkOutput("b2b_handoff_busy", 64'(busy[0]), 64'd1);
        repeat (5) begin
            applyStimulus();
            checkOutput("b2b_busy", 64'(busy[0]), 64'd1);
        end
        ap_done[0] = 1'b1; ap_continue[0] = 1'b1; applyStimulus(); idleInputs();
        checkOutput("b2b_busy_end", 64'(busy[0]), 64'd0);
        readCheck(0, 0, "b2b_txn", 2);
        readCheck(0, 5, "b2b_last", 7);
        readCheck(0, 4, "b2b_max", 7);
        readCheck(0, 1, "b2b_active", 10);

        $display("[TB] saturation");
        pulseClear();
        iter_end[2] = 1'b1;
        repeat (300) applyStimulus();
        iter_end[2] = 1'b0;
        readCheck(2, 3, "sat_iter", 255);
        checkOutput("sat_ovf", 64'(overflow), 64'd4);
        readCheck(0, 3, "sat_other_iter", 0);
        pulseClear();
        checkOutput("sat_ovf_cleared", 64'(overflow), 64'd0);
        readCheck(2, 3, "sat_iter_cleared", 0);

        $display("[TB] clear versus event");
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        ap_done[0] = 1'b1; ap_continue[0] = 1'b1; applyStimulus(); idleInputs();
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        ap_done[0] = 1'b1; ap_continue[0] = 1'b1; clear = 1'b1;
        rd_en = 1'b1; rd_ch = 2'd0; rd_field = 3'd0;
        applyStimulus();
        checkOutput("clr_read_pre", 64'(rd_data), 64'd1);
        checkOutput("clr_fsm_kept", 64'(busy[0]), 64'd0);
        idleInputs(); clear = 1'b0; rd_en = 1'b0;
        readCheck(0, 0, "clr_txn_after", 0);

        $display("[TB] enable low");
        enable = 1'b0;
        ap_start[1] = 1'b1; applyStimulus(); ap_start[1] = 1'b0;
        checkOutput("en0_busy", 64'(busy[1]), 64'd1);
        ap_done[1] = 1'b1; ap_continue[1] = 1'b1; iter_end[1] = 1'b1;
        applyStimulus(); idleInputs();
        checkOutput("en0_busy_end", 64'(busy[1]), 64'd0);
        enable = 1'b1;
        readCheck(1, 0, "en0_txn", 0);
        readCheck(1, 3, "en0_iter", 0);
        readCheck(1, 5, "en0_last", 0);

        $display("[TB] ready while held");
        ap_start[1] = 1'b1; applyStimulus(); ap_start[1] = 1'b0;
        ap_done[1] = 1'b1; applyStimulus(); ap_done[1] = 1'b0;
        ap_ready[1] = 1'b1; applyStimulus(); ap_ready[1] = 1'b0;
        checkOutput("proto_ovf", 64'(overflow), 64'd2);
        ap_continue[1] = 1'b1; applyStimulus(); ap_continue[1] = 1'b0;
        checkOutput("proto_busy_end", 64'(busy[1]), 64'd0);
        pulseClear();

        $display("[TB] reset mid-run");
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        applyStimulus();
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        #1;
        checkAll();
        ap_start[0] = 1'b1; applyStimulus(); ap_start[0] = 1'b0;
        applyStimulus();
        ap_done[0] = 1'b1; ap_continue[0] = 1'b1; applyStimulus(); idleInputs();
        readCheck(0, 5, "rst_last", 3);
        readCheck(0, 0, "rst_txn", 1);
        readCheck(3, 0, "rst_out_of_range", 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            ap_start    = NC'($urandom & $urandom);
            ap_done     = NC'($urandom & $urandom);
            ap_continue = NC'($urandom | $urandom);
            ap_ready    = NC'($urandom & $urandom & $urandom);
            iter_end    = NC'($urandom);
            enable      = ($urandom_range(0, 9) != 0);
            clear       = ($urandom_range(0, 49) == 0);
            rd_en       = 1'($urandom);
            rd_ch       = 2'($urandom_range(0, 3));
            rd_field    = 3'($urandom_range(0, 7));
            applyStimulus();
        end
        idleInputs();
        enable = 1'b1; clear = 1'b0; rd_en = 1'b0;
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
AP_CTRL_PERF_MONITOR -- requirements
Module: ap_ctrl_perf_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of monitored ap_ctrl_chain channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of every counter (8..64).
REQ-003 SHALL have derived parameter SEL_W, default max(1,clog2(N_CH)): channel-select width.
REQ-004 SHALL have port clock  in  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port enable  in  1  1 = counters update; 0 = counters frozen, FSMs still track.
REQ-007 SHALL have port clear  in  1  synchronous clear of all counters and overflow flags.
REQ-008 SHALL have ports ap_start, ap_ready, ap_done, ap_continue, each  in  N_CH  observed handshake, one bit per channel.
REQ-009 SHALL have port iter_end  in  N_CH  one-cycle pulse per completed pipelined-loop iteration.
REQ-010 SHALL have port rd_en  in  1  readout request.
REQ-011 SHALL have port rd_ch  in  SEL_W  channel to read.
REQ-012 SHALL have port rd_field  in  3  counter to read.
REQ-013 SHALL have port rd_valid  out  1  rd_data is valid.
REQ-014 SHALL have port rd_data  out  CNT_W  counter value.
REQ-015 SHALL have port busy  out  N_CH  channel FSM not in IDLE.
REQ-016 SHALL have port overflow  out  N_CH  sticky: some counter of that channel saturated.

Function
REQ-017 SHALL give each channel an independent FSM: IDLE, RUN, WAIT_CONT.
REQ-018 SHALL make these FSM transitions:
  - IDLE->RUN on ap_start.
  - RUN->WAIT_CONT on ap_done & !ap_continue.
  - RUN->IDLE on ap_done & ap_continue & !ap_start.
  - RUN->RUN on ap_done & ap_continue & ap_start (back-to-back).
  - WAIT_CONT->IDLE or ->RUN on ap_continue, using the same ap_start rule.
REQ-019 SHALL handle ap_start & ap_done in the same IDLE cycle as a 1-cycle transaction: the start-accept cycle is handled as RUN.
REQ-020 SHALL define the per-channel counters by field index:
  - 0: txn_count, +1 per done&continue handshake.
  - 1: active_cycles, +1 per cycle in RUN, including the start-accept cycle.
  - 2: stall_cycles, +1 per cycle in WAIT_CONT plus the done&!continue cycle.
  - 3: iter_count, +1 per iter_end pulse in any state.
  - 4: max_latency.
  - 5: last_latency.
  - 6, 7: read as 0.
REQ-021 SHALL count latency from the start-accept cycle (=1) through the ap_done cycle inclusive; on the done cycle, last_latency takes the new value and max_latency takes max(old, new).
REQ-022 SHALL saturate every counter at 2^CNT_W-1; any increment attempted while saturated sets overflow[ch], which stays set until clear or reset.
REQ-023 SHALL apply clear over all same-cycle events: counters and overflow go to 0, those events are dropped, and FSM state is kept.
REQ-024 SHALL hold all counters while enable=0, FSM transitions and the latency tracker still run, and last_latency/max_latency update only if enable=1 on the done cycle.
REQ-025 SHALL answer a read with 1-cycle latency: rd_en at cycle t gives rd_valid=1 at t+1 with rd_data sampled from counter values at the end of t (pre-update value).
REQ-026 SHALL return rd_data=0 for rd_ch>=N_CH, with rd_valid still 1.
REQ-027 SHALL produce rd_valid=0 and hold rd_data at its last value when rd_en=0.
REQ-028 SHALL ignore ap_ready for state; it is used only for the protocol check in REQ-029.
REQ-029 SHALL, as the protocol check, set overflow[ch] sticky if ap_ready=1 while the FSM is in WAIT_CONT.
REQ-030 SHALL drive busy[ch]=1 in RUN and in WAIT_CONT.

Reset
REQ-031 SHALL, while reset=0 (asynchronously), put all FSMs in IDLE and set all counters, overflow, busy, rd_valid and rd_data to 0.
REQ-032 SHALL, on reset asserted mid-transaction, discard the in-flight latency; the first transaction after release is measured from its own ap_start.
REQ-033 SHALL leave outputs at reset values until the first rising clock edge after reset releases.

Verification
REQ-034 SHALL cover single transaction: ch0 ap_start 1 cycle, ap_done+ap_continue 5 cycles later -> txn=1, active=6, stall=0, last=max=6.
REQ-035 SHALL cover backpressure: ap_done held with ap_continue=0 for 3 cycles, then continue -> stall=4, txn=1, busy high throughout.
REQ-036 SHALL cover back-to-back: latencies 4 then 7 with ap_start in the handoff cycle -> txn=2, last=7, max=7, no IDLE cycle, busy never drops.
REQ-037 SHALL cover saturation: CNT_W=8, 300 iter_end pulses on ch2 -> iter_count=255, overflow[2]=1, other channels unaffected; clear -> 0.
REQ-038 SHALL cover clear vs event: clear coincident with a done&continue -> txn=0 next cycle; a read in the same cycle returns the pre-clear value.
REQ-039 SHALL cover reset mid-run: reset low during RUN for 2 cycles, then a 3-cycle transaction -> last_latency=3, txn=1, rd_ch=N_CH reads 0.
